// File: rtl/serial_job_arbiter_if.sv
// Requester and shared-counter signals of serial_job_arbiter.
// slave: arbiter side; master: requesters plus counter side.
interface serial_job_arbiter_if #(
    parameter int WIDTH = 8
);
    // requester side
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] pat0;
    logic [WIDTH-1:0] pat1;
    logic             gnt0;
    logic             gnt1;
    logic             done;
    logic [7:0]       result;
    logic             owner;
    logic             busy;
    // shared counter side
    logic             ctr_clr;
    logic             sin;
    logic [7:0]       count;

    modport slave (
        input  req0, req1, pat0, pat1, count,
        output gnt0, gnt1, done, result, owner, busy,
        output ctr_clr, sin
    );

    modport master (
        output req0, req1, pat0, pat1, count,
        input  gnt0, gnt1, done, result, owner, busy,
        input  ctr_clr, sin
    );
endinterface

// File: rtl/serial_job_arbiter.sv
// Shares one serial-input counter between two requesters: round-robin grant,
// counter clear, LSB-first shift on sin, settle, sample count, done pulse.
// Ports: clk, rst (async, active-low), bus (serial_job_arbiter_if.slave):
//   req0/req1, pat0/pat1 in; gnt0/gnt1, done, result, owner, busy out;
//   ctr_clr, sin out to the counter; count in from the counter.
module serial_job_arbiter #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input logic                 clk,
    input logic                 rst,
    serial_job_arbiter_if.slave bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [4:0]    BLAST = 5'(WIDTH - 1);
    localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        SETL,
        REPORT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [4:0]       bitcnt;
    logic [SW-1:0]    setcnt;
    logic             last_owner;
    logic             win;

    // On a tie the requester that did not own the last job wins.
    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            (bus.req0 & bus.req1):  win = ~last_owner;
            (bus.req1 & ~bus.req0): win = 1'b1;
            default:                win = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            setcnt      <= '0;
            last_owner  <= 1'b1;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.ctr_clr <= 1'b0;
            bus.sin     <= 1'b0;
            bus.done    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.result  <= 8'd0;
            bus.owner   <= 1'b0;
        end else begin
            // pulse outputs default low; each state sets what it needs
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.ctr_clr <= 1'b0;
            bus.sin     <= 1'b0;
            bus.done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state       <= CLEAR;
                        shreg       <= win ? bus.pat1 : bus.pat0;
                        bus.owner   <= win;
                        bus.gnt0    <= ~win;
                        bus.gnt1    <= win;
                        bus.ctr_clr <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    // sin is registered, so bit 0 is loaded here to be
                    // on the wire during SHIFT cycle 0
                    state   <= SHIFT;
                    bitcnt  <= '0;
                    bus.sin <= shreg[0];
                    shreg   <= shreg >> 1;
                end
                SHIFT: begin
                    if (bitcnt == BLAST) begin
                        state  <= SETL;
                        setcnt <= '0;
                    end else begin
                        bitcnt  <= bitcnt + 5'd1;
                        bus.sin <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                SETL: begin
                    if (setcnt == SLAST) begin
                        state      <= REPORT;
                        bus.result <= bus.count;
                        bus.done   <= 1'b1;
                    end else begin
                        setcnt <= setcnt + 1'b1;
                    end
                end
                REPORT: begin
                    state      <= IDLE;
                    last_owner <= bus.owner;
                    bus.busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_job_arbiter.sv
// Directed, table-driven bench for serial_job_arbiter.
// A ones-counter stands in for the shared serial counter.
module tb_serial_job_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_job_arbiter_if #(.WIDTH(8)) bus ();

    serial_job_arbiter #(
        .WIDTH (8),
        .SETTLE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counter model: counts ones seen on sin, synchronous clear
    always_ff @(posedge clk) begin
        if (bus.ctr_clr)
            bus.count <= 8'd0;
        else if (bus.sin)
            bus.count <= bus.count + 8'd1;
    end

    typedef struct {
        bit         who;
        logic [7:0] pat;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
        chk({tag, " done seen"}, int'(bus.done), 1);
    endtask

    // full single-requester job, DUT assumed idle on entry
    task automatic job(input bit who, input logic [7:0] pat,
                       input logic [7:0] res, input string tag);
        int n;
        int m;
        if (who) begin
            bus.req1 = 1'b1;
            bus.pat1 = pat;
        end else begin
            bus.req0 = 1'b1;
            bus.pat0 = pat;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(who ? bus.gnt1 : bus.gnt0) && n < 20);
        chk({tag, " gnt latency"}, n, 1);
        chk({tag, " other gnt"}, int'(who ? bus.gnt0 : bus.gnt1), 0);
        chk({tag, " ctr_clr"}, int'(bus.ctr_clr), 1);
        chk({tag, " busy"}, int'(bus.busy), 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("%s sin%0d", tag, k), int'(bus.sin), int'(pat[k]));
            if (k == 0)
                chk({tag, " ctr_clr off"}, int'(bus.ctr_clr), 0);
        end
        wait_done(tag, m);
        chk({tag, " gnt->done"}, 8 + m, 11);
        chk({tag, " result"}, int'(bus.result), int'(res));
        chk({tag, " owner"}, int'(bus.owner), int'(who));
        @(negedge clk);
        chk({tag, " done pulse"}, int'(bus.done), 0);
        chk({tag, " idle busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int gcnt;
        int dcnt;
        int gord[3];
        int oord[3];
        int t1;
        int t2;
        int g0;
        int n;
        int c;
        int dc;
        int gc;

        checks = 0;
        errors = 0;
        vecs[0] = '{1'b1, 8'h00, 8'd0};
        vecs[1] = '{1'b0, 8'hFF, 8'd8};
        vecs[2] = '{1'b1, 8'h81, 8'd2};
        vecs[3] = '{1'b0, 8'h01, 8'd1};
        vecs[4] = '{1'b1, 8'h80, 8'd1};
        vecs[5] = '{1'b0, 8'hA5, 8'd4};

        // reset held with req0 high
        rst = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.pat0 = 8'b0101_0101;
        bus.pat1 = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst gnt0", int'(bus.gnt0), 0);
            chk("rst gnt1", int'(bus.gnt1), 0);
            chk("rst outs", int'({bus.ctr_clr, bus.sin, bus.done,
                                  bus.busy, bus.owner}), 0);
            chk("rst result", int'(bus.result), 0);
        end
        rst = 1'b1;
        job(1'b0, 8'b0101_0101, 8'd4, "single");

        foreach (vecs[i])
            job(vecs[i].who, vecs[i].pat, vecs[i].res, $sformatf("vec%0d", i));

        // tie from reset release: order 0,1,0
        rst = 1'b0;
        @(negedge clk);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.pat0 = 8'h03;
        bus.pat1 = 8'h07;
        rst = 1'b1;
        gcnt = 0;
        dcnt = 0;
        gord = '{9, 9, 9};
        oord = '{9, 9, 9};
        c = 0;
        while (c < 60 && dcnt < 3) begin
            @(negedge clk);
            c++;
            if (bus.gnt0 || bus.gnt1) begin
                if (gcnt < 3)
                    gord[gcnt] = int'(bus.gnt1);
                gcnt++;
            end
            if (bus.done) begin
                if (dcnt < 3)
                    oord[dcnt] = int'(bus.owner);
                dcnt++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("tie grants", gcnt, 3);
        chk("tie dones", dcnt, 3);
        chk("tie gnt order0", gord[0], 0);
        chk("tie gnt order1", gord[1], 1);
        chk("tie gnt order2", gord[2], 0);
        chk("tie owner0", oord[0], 0);
        chk("tie owner1", oord[1], 1);
        chk("tie owner2", oord[2], 0);
        chk("tie result", int'(bus.result), 2);
        @(negedge clk);
        @(negedge clk);

        // lone repeater on req1
        bus.req1 = 1'b1;
        bus.pat1 = 8'h3C;
        gc = 0;
        g0 = 0;
        t1 = 0;
        t2 = 0;
        c = 0;
        while (c < 60 && gc < 2) begin
            @(negedge clk);
            c++;
            if (bus.gnt0)
                g0++;
            if (bus.gnt1) begin
                if (gc == 0)
                    t1 = c;
                else
                    t2 = c;
                gc++;
            end
        end
        bus.req1 = 1'b0;
        chk("lone gnt1 count", gc, 2);
        chk("lone period", t2 - t1, 13);
        wait_done("lone", n);
        chk("lone gnt0", g0, 0);
        chk("lone result", int'(bus.result), 4);
        chk("lone owner", int'(bus.owner), 1);
        @(negedge clk);

        // late request raised during SHIFT of a req0 job
        bus.req0 = 1'b1;
        bus.pat0 = 8'h0F;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gnt0 && n < 20);
        chk("late gnt0", int'(bus.gnt0), 1);
        bus.req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.req1 = 1'b1;
        bus.pat1 = 8'hF0;
        dc = -1;
        gc = -1;
        c = 0;
        while (c < 40 && gc < 0) begin
            @(negedge clk);
            c++;
            if (bus.done && dc < 0)
                dc = c;
            if (bus.gnt1)
                gc = c;
            chk("late gnt0 none", int'(bus.gnt0), 0);
        end
        bus.req1 = 1'b0;
        chk("late done->gnt1", gc - dc, 2);
        wait_done("late", n);
        chk("late result", int'(bus.result), 4);
        chk("late owner", int'(bus.owner), 1);
        @(negedge clk);

        // reset during SHIFT bit 3
        bus.req0 = 1'b1;
        bus.pat0 = 8'hFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gnt0 && n < 20);
        bus.req0 = 1'b0;
        for (int k = 0; k < 4; k++)
            @(negedge clk);
        chk("mid sin before", int'(bus.sin), 1);
        chk("mid busy before", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk("mid sin", int'(bus.sin), 0);
        chk("mid busy", int'(bus.busy), 0);
        chk("mid ctr_clr", int'(bus.ctr_clr), 0);
        chk("mid result", int'(bus.result), 0);
        dc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done)
                dc++;
        end
        rst = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.done)
                dc++;
        end
        chk("mid no done", dc, 0);
        job(1'b1, 8'hFF, 8'd8, "after rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_job_arbiter.md
# serial_job_arbiter

Controller that shares one serial-input counter (clk/rst, 1-bit `sin`, 8-bit `count`) between two requesters. It accepts a parallel pattern from the winning requester under round-robin arbitration, clears the counter, and shifts the pattern LSB-first onto `sin`. After a settle window it samples the counter's `count` and returns it to the requester with a done pulse. It sits between the requester logic and the shared counter datapath.

## Interface
- `WIDTH`, 8: pattern length in bits; legal range 1..16.
- `SETTLE`, 2: idle cycles after the last shifted bit before sampling `count`; legal range ≥1.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req0`, `req1`  in  1: job requests, level; held until the matching grant.
- `pat0`, `pat1`  in  WIDTH: patterns, stable while the matching `req` is high.
- `gnt0`, `gnt1`  out  1: one-cycle grant pulses.
- `ctr_clr`  out  1: synchronous clear to the shared counter.
- `sin`  out  1: serial data to the shared counter.
- `count`  in  8: counter value.
- `done`  out  1: one-cycle job-complete pulse.
- `result`  out  8: sampled `count`; held until the next job completes.
- `owner`  out  1: requester index of the current or last job.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE → CLEAR → SHIFT → SETTLE → REPORT → IDLE.
- IDLE: if any `req` is high, at the clock edge:
  - latch the winner's pattern into the shift register;
  - set `owner`;
  - go to CLEAR.
- Arbitration:
  - If only one request is high, that requester wins.
  - If both are high, the winner is the requester that is not `last_owner`.
  - `last_owner` resets to 1, so `req0` wins the first tie.
  - `last_owner` updates in REPORT.
- Requests are sampled only in IDLE. `req` asserted while `busy` waits; it is never dropped and never double-granted.
- CLEAR (1 cycle):
  - `gnt<owner>` = 1, `ctr_clr` = 1, `sin` = 0.
  - Requester may drop `req` and change `pat` from the next cycle.
- SHIFT (WIDTH cycles):
  - In SHIFT cycle k (k = 0..WIDTH-1), `sin` = pattern bit k (LSB first).
  - Bit counter runs 0..WIDTH-1, then go to SETTLE.
- SETTLE (SETTLE cycles): `sin` = 0; the counter finishes absorbing the last bit.
- Entering REPORT: `result` <= `count` as sampled at the edge leaving the last SETTLE cycle.
- REPORT (1 cycle): `done` = 1, `owner` still valid, `last_owner` <= `owner`; then go to IDLE.
- Outside CLEAR/SHIFT, `ctr_clr` = 0 and `sin` = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (`rst` = 0):
  - State = IDLE.
  - All outputs = 0: `gnt0`, `gnt1`, `ctr_clr`, `sin`, `done`, `busy`, `result` = 8'd0, `owner` = 0.
  - `last_owner` = 1; shift register and bit counter = 0.
  - Reset takes effect immediately, including mid-job.
  - An aborted job produces no `done`. Its requester, having seen `gnt`, re-requests on a timeout (requester responsibility).

## Timing
- Let the grant cycle be G (the CLEAR cycle).
  - SHIFT occupies G+1..G+WIDTH.
  - SETTLE occupies G+WIDTH+1..G+WIDTH+SETTLE.
  - REPORT is G+WIDTH+SETTLE+1.
- With defaults, `done` comes 11 cycles after `gnt`.
- Request-to-grant: 1 cycle from IDLE; `gnt` is high in the cycle after `req` is first sampled high in IDLE.
- Back-to-back jobs: at least one IDLE cycle between REPORT and the next CLEAR.
  - Job period with defaults = 13 cycles.
- `busy` is high from CLEAR through REPORT inclusive.
- `result` changes only at entry to REPORT.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `req0` = 1.
  - Required: all outputs 0, no `gnt` during reset.
  - After release: `gnt0` one cycle later.
- Single job: `req0` = 1, `pat0` = 8'b0101_0101; counter model returns 8'd4.
  - Required: `ctr_clr` for 1 cycle.
  - `sin` = 1,0,1,0,1,0,1,0 over 8 cycles.
  - `done` 11 cycles after `gnt0`, with `result` = 8'd4 and `owner` = 0.
- Tie: `req0` and `req1` held high from reset release for three jobs.
  - Required: grant order 0,1,0; `owner` at each `done` = 0,1,0.
- Lone repeater: `req1` held high continuously for two jobs.
  - Required: two `gnt1` pulses 13 cycles apart; `gnt0` never asserted.
- Late request: raise `req1` during SHIFT of a `req0` job.
  - Required: `gnt1` exactly 2 cycles after the `req0` job's `done` (REPORT, IDLE, then CLEAR).
- Reset mid-job: drop `rst` during SHIFT bit 3.
  - Required: `sin`, `busy` and `ctr_clr` go to 0 immediately; no `done`.
  - After release, a new `req1` job with `pat1` = 8'hFF completes normally.
